reg_file_clr: RTL and testbench

- Parametrised successor to the 4x8 datapath register file.
- Generalised data width and depth; optional hardwired zero register; optional write-to-read bypass.
- Adds an asynchronous active-low reset and a sequential clear engine that zeroes one register per cycle on request.
- Sits between decode and ALU: two operand read ports and one destination read port (read-modify-write instructions), one write port from writeback.

---
 rtl/reg_file_clr.sv | 105 ++++++++++
 tb/tb_reg_file_clr.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_file_clr.sv
// Parametrised register file with three combinational read ports, one write
// port, optional zero register / write bypass, and a one-entry-per-cycle clear sweep.
module reg_file_clr #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int DEPTH    = 2**ADDR_W;
  localparam int NUM_RD   = 3;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             ptr;
  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic                          wr_drop;
  logic                          wr_commit;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  // rst_n gating keeps ack and bypass quiet while reset is held
  assign wr_ack    = wr_en & ~clr_busy & rst_n;
  assign wr_drop   = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_commit = wr_ack & ~wr_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (wr_commit)      regs[wr_addr] <= wr_data;
      if (state == SWEEP) regs[ptr]     <= '0;
    end
  end

  assign raddr = {wr_addr, rd_addr2, rd_addr1};

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if ((ZERO_REG != 0) && (raddr[p] == '0))
        rdata[p] = '0;
      else if ((BYPASS != 0) && wr_commit && (raddr[p] == wr_addr))
        rdata[p] = wr_data;
      else
        rdata[p] = regs[raddr[p]];
    end
  end

  assign rd_data1 = rdata[0];
  assign rd_data2 = rdata[1];
  assign rd_data3 = rdata[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= SWEEP;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        SWEEP: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == ADDR_W'(DEPTH-1)) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_clr.sv
// Scoreboard bench for reg_file_clr: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares against the default, no-bypass and zero-reg builds.
module tb_reg_file_clr;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0;
  logic       wr_en = 1'b0, clr_req = 1'b0;
  logic [7:0] wr_data = '0;

  logic [7:0] rd1, rd2, rd3, nb_rd1, nb_rd2, nb_rd3, z_rd1, z_rd2, z_rd3;
  logic       ack, busy, done, nb_ack, nb_busy, nb_done, z_ack, z_busy, z_done;

  always #5 clk = ~clk;

  reg_file_clr #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_data1(rd1), .rd_data2(rd2), .rd_data3(rd3),
    .wr_ack(ack), .clr_req(clr_req), .clr_busy(busy), .clr_done(done));

  reg_file_clr #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_data1(nb_rd1), .rd_data2(nb_rd2), .rd_data3(nb_rd3),
    .wr_ack(nb_ack), .clr_req(clr_req), .clr_busy(nb_busy), .clr_done(nb_done));

  reg_file_clr #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_data1(z_rd1), .rd_data2(z_rd2), .rd_data3(z_rd3),
    .wr_ack(z_ack), .clr_req(clr_req), .clr_busy(z_busy), .clr_done(z_done));

  typedef struct {
    string      nm;
    logic [7:0] d1, d2, d3;
    logic       ack, busy, done;
    bit         cnb;
    logic [7:0] nb1;
    bit         cz;
    logic [7:0] z1;
    logic       zack;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit         nb_chk = 0, z_chk = 0;
  logic [7:0] nb_exp = '0, z_exp = '0;
  logic       zack_exp = 1'b0;

  task automatic cmp(input string nm, input string f, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, f, act, exp, $time);
    end
  endtask

  // monitor: outputs are combinational, so every queued step is sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp(e.nm, "rd_data1", rd1, e.d1);
        cmp(e.nm, "rd_data2", rd2, e.d2);
        cmp(e.nm, "rd_data3", rd3, e.d3);
        cmp(e.nm, "wr_ack", {7'd0, ack}, {7'd0, e.ack});
        cmp(e.nm, "clr_busy", {7'd0, busy}, {7'd0, e.busy});
        cmp(e.nm, "clr_done", {7'd0, done}, {7'd0, e.done});
        if (e.cnb) cmp(e.nm, "nobypass_rd_data1", nb_rd1, e.nb1);
        if (e.cz) begin
          cmp(e.nm, "zeroreg_rd_data1", z_rd1, e.z1);
          cmp(e.nm, "zeroreg_wr_ack", {7'd0, z_ack}, {7'd0, e.zack});
        end
      end
    end
  end

  task automatic cyc(input logic rn, input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] aw,
                     input logic we, input logic [7:0] wd, input logic cr, input string nm,
                     input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                     input logic eack, input logic ebusy, input logic edone);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; rd_addr1 = a1; rd_addr2 = a2; wr_addr = aw;
    wr_en = we; wr_data = wd; clr_req = cr;
    e.nm = nm; e.d1 = e1; e.d2 = e2; e.d3 = e3;
    e.ack = eack; e.busy = ebusy; e.done = edone;
    e.cnb = nb_chk; e.nb1 = nb_exp; e.cz = z_chk; e.z1 = z_exp; e.zack = zack_exp;
    q.push_back(e);
    nb_chk = 0; z_chk = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // reset held: write request must not be acked nor bypassed
    cyc(0, 0, 1, 2, 1, 8'hFF, 0, "rst_wr",   8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc(0, 3, 3, 3, 0, 8'h00, 0, "rst_rd3",  8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc(1, 0, 1, 2, 0, 8'h00, 0, "rel",      8'h00, 8'h00, 8'h00, 0, 0, 0);
    // bypass vs no-bypass
    nb_chk = 1; nb_exp = 8'h00;
    cyc(1, 2, 3, 2, 1, 8'hA5, 0, "byp_wr",   8'hA5, 8'h00, 8'hA5, 1, 0, 0);
    nb_chk = 1; nb_exp = 8'hA5;
    cyc(1, 2, 2, 2, 0, 8'h00, 0, "byp_rd",   8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
    // zero register build drops the write but still acks
    z_chk = 1; z_exp = 8'h00; zack_exp = 1;
    cyc(1, 0, 2, 0, 1, 8'hFF, 0, "zr_wr",    8'hFF, 8'hA5, 8'hFF, 1, 0, 0);
    z_chk = 1; z_exp = 8'h00; zack_exp = 0;
    cyc(1, 0, 1, 0, 0, 8'h00, 0, "zr_rd",    8'hFF, 8'h00, 8'hFF, 0, 0, 0);
    // load r0..r3
    cyc(1, 0, 3, 0, 1, 8'h11, 0, "ld0",      8'h11, 8'h00, 8'h11, 1, 0, 0);
    cyc(1, 0, 1, 1, 1, 8'h22, 0, "ld1",      8'h11, 8'h22, 8'h22, 1, 0, 0);
    cyc(1, 2, 1, 2, 1, 8'h33, 0, "ld2",      8'h33, 8'h22, 8'h33, 1, 0, 0);
    cyc(1, 3, 0, 3, 1, 8'h44, 0, "ld3",      8'h44, 8'h11, 8'h44, 1, 0, 0);
    // sweep: clr_req sampled at the end of "clr_k"
    cyc(1, 0, 3, 3, 0, 8'h00, 1, "clr_k",    8'h11, 8'h44, 8'h44, 0, 0, 0);
    cyc(1, 0, 3, 1, 1, 8'hEE, 0, "sw1",      8'h11, 8'h44, 8'h22, 0, 1, 0);
    cyc(1, 0, 3, 1, 1, 8'hEE, 1, "sw2",      8'h00, 8'h44, 8'h22, 0, 1, 0);
    cyc(1, 1, 2, 3, 0, 8'h00, 0, "sw3",      8'h00, 8'h33, 8'h44, 0, 1, 0);
    cyc(1, 2, 3, 0, 0, 8'h00, 0, "sw4",      8'h00, 8'h44, 8'h00, 0, 1, 0);
    cyc(1, 3, 1, 2, 1, 8'h5A, 0, "sw_done",  8'h00, 8'h00, 8'h5A, 1, 0, 1);
    cyc(1, 2, 0, 3, 0, 8'h00, 0, "sw_idle",  8'h5A, 8'h00, 8'h00, 0, 0, 0);
    // write accepted in the clr_req cycle, then cleared in its slot
    cyc(1, 1, 2, 1, 1, 8'h7E, 1, "wc_k",     8'h7E, 8'h5A, 8'h7E, 1, 0, 0);
    cyc(1, 1, 2, 0, 0, 8'h00, 0, "wc1",      8'h7E, 8'h5A, 8'h00, 0, 1, 0);
    cyc(1, 1, 2, 0, 0, 8'h00, 0, "wc2",      8'h7E, 8'h5A, 8'h00, 0, 1, 0);
    cyc(1, 1, 2, 0, 0, 8'h00, 0, "wc3",      8'h00, 8'h5A, 8'h00, 0, 1, 0);
    cyc(1, 1, 2, 0, 0, 8'h00, 0, "wc4",      8'h00, 8'h00, 8'h00, 0, 1, 0);
    cyc(1, 1, 2, 0, 0, 8'h00, 0, "wc_done",  8'h00, 8'h00, 8'h00, 0, 0, 1);
    // async reset in the middle of a sweep
    cyc(1, 3, 0, 3, 1, 8'h99, 0, "mr_ld",    8'h99, 8'h00, 8'h99, 1, 0, 0);
    cyc(1, 3, 3, 3, 0, 8'h00, 1, "mr_k",     8'h99, 8'h99, 8'h99, 0, 0, 0);
    cyc(1, 3, 3, 3, 0, 8'h00, 0, "mr_sw1",   8'h99, 8'h99, 8'h99, 0, 1, 0);
    cyc(0, 3, 3, 3, 0, 8'h00, 0, "mr_rst",   8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc(0, 3, 2, 1, 0, 8'h00, 0, "mr_hold",  8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc(1, 3, 2, 1, 0, 8'h00, 1, "mr_k2",    8'h00, 8'h00, 8'h00, 0, 0, 0);
    cyc(1, 3, 2, 1, 1, 8'h12, 0, "mr_sw_a",  8'h00, 8'h00, 8'h00, 0, 1, 0);
    cyc(1, 3, 2, 1, 0, 8'h00, 0, "mr_sw_b",  8'h00, 8'h00, 8'h00, 0, 1, 0);
    cyc(1, 3, 2, 1, 0, 8'h00, 0, "mr_sw_c",  8'h00, 8'h00, 8'h00, 0, 1, 0);
    cyc(1, 3, 2, 1, 0, 8'h00, 0, "mr_sw_d",  8'h00, 8'h00, 8'h00, 0, 1, 0);
    cyc(1, 3, 2, 1, 0, 8'h00, 0, "mr_done",  8'h00, 8'h00, 8'h00, 0, 0, 1);
    cyc(1, 3, 2, 1, 0, 8'h00, 0, "mr_idle",  8'h00, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
